// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencing controller with committed HI/LO registers.
// Optional madd/maddu accumulate enabled by defining MDU_MADD_EN.
module md_unit_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        rd_sel,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      MULT_BUSY,
      DIV_BUSY
   } state_t;

   localparam logic [3:0] MC = 4'(MULT_CYCLES);
   localparam logic [3:0] DC = 4'(DIV_CYCLES);

   state_t      state;
   logic [3:0]  cnt;
   logic [63:0] pend;
   logic        pend_ok;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        a_neg;
   logic        b_neg;
   logic        dz;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_safe;
   logic [31:0] rt_safe;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] q_s;
   logic [31:0] r_s;
   logic [31:0] q_u;
   logic [31:0] r_u;

   // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly.
   always_comb begin
      prod_s  = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
      prod_u  = {32'd0, rs_data} * {32'd0, rt_data};
      a_neg   = rs_data[31];
      b_neg   = rt_data[31];
      dz      = (rt_data == 32'd0);
      a_mag   = a_neg ? (32'd0 - rs_data) : rs_data;
      b_mag   = b_neg ? (32'd0 - rt_data) : rt_data;
      b_safe  = dz ? 32'd1 : b_mag;
      rt_safe = dz ? 32'd1 : rt_data;
      uq      = a_mag / b_safe;
      ur      = a_mag % b_safe;
      q_s     = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
      r_s     = a_neg ? (32'd0 - ur) : ur;
      q_u     = rs_data / rt_safe;
      r_u     = rs_data % rt_safe;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         pend    <= 64'd0;
         pend_ok <= 1'b0;
         busy    <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  case (md_op)
                     4'd1: begin
                        pend    <= prod_s;
                        pend_ok <= 1'b1;
                        cnt     <= MC;
                        busy    <= 1'b1;
                        state   <= MULT_BUSY;
                     end
                     4'd2: begin
                        pend    <= prod_u;
                        pend_ok <= 1'b1;
                        cnt     <= MC;
                        busy    <= 1'b1;
                        state   <= MULT_BUSY;
                     end
                     4'd3: begin
                        pend    <= {r_s, q_s};
                        pend_ok <= !dz;
                        cnt     <= DC;
                        busy    <= 1'b1;
                        state   <= DIV_BUSY;
                     end
                     4'd4: begin
                        pend    <= {r_u, q_u};
                        pend_ok <= !dz;
                        cnt     <= DC;
                        busy    <= 1'b1;
                        state   <= DIV_BUSY;
                     end
                     4'd5: hi <= rs_data;
                     4'd6: lo <= rs_data;
`ifdef MDU_MADD_EN
                     4'd7: begin
                        pend    <= {hi, lo} + prod_s;
                        pend_ok <= 1'b1;
                        cnt     <= MC;
                        busy    <= 1'b1;
                        state   <= MULT_BUSY;
                     end
                     4'd8: begin
                        pend    <= {hi, lo} + prod_u;
                        pend_ok <= 1'b1;
                        cnt     <= MC;
                        busy    <= 1'b1;
                        state   <= MULT_BUSY;
                     end
`endif
                     default: ;
                  endcase
               end
            end
            MULT_BUSY, DIV_BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1) begin
                  if (pend_ok) begin
                     hi <= pend[63:32];
                     lo <= pend[31:0];
                  end
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign md_rdata = rd_sel ? hi : lo;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: expected HI/LO queued at issue,
// popped and compared when the unit goes idle.
module tb_md_unit_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        rd_sel;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic [63:0] sb[$];

   md_unit_ctrl #(
      .MULT_CYCLES(MC),
      .DIV_CYCLES (DC)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .md_op   (md_op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .rd_sel  (rd_sel),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo),
      .md_rdata(md_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit inj);
      logic [63:0] e;
      logic [63:0] got_e;
      int          n_exp;
      int          n;
      int          qi;
      int          ri;
      e     = {m_hi, m_lo};
      n_exp = 0;
      case (op)
         4'd1: begin
            e = 64'(longint'(signed'(a)) * longint'(signed'(b)));
            n_exp = MC;
         end
         4'd2: begin
            e = 64'(a) * 64'(b);
            n_exp = MC;
         end
         4'd3: begin
            if (b != 0) begin
               qi = int'(signed'(a)) / int'(signed'(b));
               ri = int'(signed'(a)) % int'(signed'(b));
               e = {32'(ri), 32'(qi)};
            end
            n_exp = DC;
         end
         4'd4: begin
            if (b != 0) e = {a % b, a / b};
            n_exp = DC;
         end
         4'd5: e[63:32] = a;
         4'd6: e[31:0] = a;
`ifdef MDU_MADD_EN
         4'd7: begin
            e = {m_hi, m_lo} + 64'(longint'(signed'(a)) * longint'(signed'(b)));
            n_exp = MC;
         end
         4'd8: begin
            e = {m_hi, m_lo} + 64'(a) * 64'(b);
            n_exp = MC;
         end
`endif
         default: ;
      endcase
      m_hi = e[63:32];
      m_lo = e[31:0];
      sb.push_back(e);
      @(negedge clk);
      start   = 1'b1;
      md_op   = op;
      rs_data = a;
      rt_data = b;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         n++;
         if (inj && n == 1) begin
            start   = 1'b1;
            md_op   = 4'd1;
            rs_data = 32'h0000_0007;
            rt_data = 32'h0000_0009;
         end
         if (inj && n == 2) start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, "_busy"}, 64'(n), 64'(n_exp));
      got_e = sb.pop_front();
      chk({tag, "_hilo"}, {hi, lo}, got_e);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [3:0]  rop;
      reset   = 1'b1;
      start   = 1'b0;
      md_op   = 4'd0;
      rs_data = 32'd0;
      rt_data = 32'd0;
      rd_sel  = 1'b0;
      m_hi    = 32'd0;
      m_lo    = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);

      run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
      chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      run_op("divu", 4'd4, 32'd7, 32'd2, 1'b0);
      chk("divu_const", {hi, lo}, {32'd1, 32'd3});
      run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

      run_op("mthi", 4'd5, 32'h1234_5678, 32'd0, 1'b0);
      rd_sel = 1'b1;
      #1 chk("mfhi", 64'(md_rdata), 64'h1234_5678);
      rd_sel = 1'b0;
      #1 chk("mflo", 64'(md_rdata), 64'(m_lo));

      run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("mthi_a", 4'd5, 32'h0000_000A, 32'd0, 1'b0);
      run_op("mtlo_b", 4'd6, 32'h0000_000B, 32'd0, 1'b0);
      run_op("div0", 4'd3, 32'd5, 32'd0, 1'b1);
      chk("div0_const", {hi, lo}, {32'hA, 32'hB});
      run_op("nop0", 4'd0, 32'h55, 32'h66, 1'b0);
      run_op("nop9", 4'd9, 32'h55, 32'h66, 1'b0);

      run_op("mthi0", 4'd5, 32'd0, 32'd0, 1'b0);
      run_op("mtlo1", 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
      run_op("maddu", 4'd8, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
      chk("maddu_const", {hi, lo}, {32'd1, 32'd0});
`else
      chk("maddu_const", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
`endif
      run_op("madd", 4'd7, 32'hFFFF_FFFF, 32'd2, 1'b0);

      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom;
         case (i % 4)
            0: rop = 4'd1;
            1: rop = 4'd2;
            2: rop = 4'd3;
            default: rop = 4'd4;
         endcase
         if (rb == 32'd0) rb = 32'd3;
         if (ra == 32'h8000_0000) ra = 32'h7FFF_0000;
         run_op("rnd", rop, ra, rb, 1'b0);
      end

      @(negedge clk);
      start   = 1'b1;
      md_op   = 4'd4;
      rs_data = 32'd100;
      rt_data = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (DC + 3) @(negedge clk);
      chk("arst_nocommit", {hi, lo}, 64'd0);
      chk("arst_idle", 64'(busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Sequencing controller for the E-stage multiply/divide datapath and its HI/LO registers.
- Accepts one mult/div/move request at a time and models the fixed multi-cycle latency.
- Exposes busy to the hazard unit so it can stall.
- Supplies mfhi/mflo read data, which the pipeline carries forward onto the GRF write-data path.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled); legal range 1..15
DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request strobe, qualifies md_op for this cycle
md_op  input  4  1=mult 2=multu 3=div 4=divu 5=mthi 6=mtlo 7=madd 8=maddu; 0 and others = no-op
rs_data  input  32  operand A (forwarded rs value)
rt_data  input  32  operand B (forwarded rt value)
rd_sel  input  1  0=read LO, 1=read HI
busy  output  1  unit occupied by a multi-cycle operation
hi  output  32  committed HI register
lo  output  32  committed LO register
md_rdata  output  32  rd_sel ? hi : lo, combinational from committed registers

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, counter=0, busy=0, hi=0, lo=0, pending result discarded.
- States:
  - IDLE: no operation in flight.
  - MULT_BUSY: multiply result pending.
  - DIV_BUSY: divide result pending.
- IDLE, start=1, md_op in {1,2}:
  - Compute the 64-bit product at the edge. mult is signed×signed; multu is unsigned×unsigned.
  - Latch the product into a pending register.
  - Load counter=MULT_CYCLES; go to MULT_BUSY.
- IDLE, start=1, md_op in {3,4}:
  - Pending LO=quotient, pending HI=remainder. div is signed, truncating toward zero, remainder takes the dividend's sign; divu is unsigned.
  - Load counter=DIV_CYCLES; go to DIV_BUSY.
- IDLE, start=1, md_op=5/6:
  - Next edge: hi<=rs_data (mthi) or lo<=rs_data (mtlo).
  - busy stays 0; no state change.
- Busy states:
  - Counter decrements every edge.
  - busy=1 for exactly N cycles, starting the cycle after start is sampled.
  - On the edge where the counter goes 1→0: commit pending {HI,LO} into hi/lo and return to IDLE.
  - busy=0 from the following cycle; the new hi/lo are visible in that same cycle.
- start while busy=1 is ignored, including mthi/mtlo; the hazard unit stalls on (start|busy).
- Divide by zero: runs the full DIV_CYCLES; on completion hi/lo are left unchanged (no commit).
- md_op 0 or an undefined code with start=1 is a no-op; state is unchanged.
- The operand registers sample only on the accepting edge. rs_data/rt_data changes during busy have no effect.
- md_rdata always reflects committed hi/lo, never pending values. An mfhi/mflo issued while busy is stalled externally.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - md_op=7 (madd): pending {HI,LO} = {hi,lo} + signed(rs)×signed(rt), using 64-bit wrap-around.
  - md_op=8 (maddu): the same accumulate with unsigned operands.
  - Both use the MULT_CYCLES latency.
  - The accumulate base is {hi,lo} sampled at the accepting edge.
- Undefined: codes 7 and 8 are no-ops like any undefined code, and no accumulate adder is synthesized.

Test Plan:
- Reset, then mult rs=0xFFFFFFFE rt=3 (-2×3) → busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- divu rs=7 rt=2 → busy for 10 cycles → lo=3, hi=1. Then div rs=0xFFFFFFF9 (-7) rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- mthi rs=0x12345678, then mflo/mfhi → hi=0x12345678 on the next cycle, busy never asserted; md_rdata with rd_sel=1 = 0x12345678.
- div by zero with hi=0xA, lo=0xB preset via mthi/mtlo → busy 10 cycles, then hi=0xA, lo=0xB unchanged. A mult start during busy is ignored: no extra busy cycles.
- Assert reset at cycle 3 of a div → busy=0, hi=lo=0 immediately (asynchronous); no commit occurs later.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then maddu rs=1 rt=1 → after 5 cycles hi=1, lo=0. Without MDU_MADD_EN: the same op leaves hi=0, lo=0xFFFFFFFF and busy stays 0.
